// File: rtl/nn_pkg.sv
// nn_pkg: shared types and arithmetic for the neural_net inference layer.
//
// Contents:
//   DATA_W, FRAC_BITS : default word width and fractional bits of the signed
//                       Q(DATA_W-FRAC_BITS).FRAC_BITS fixed-point format
//   data_t            : signed data word used for inputs, weights, biases,
//                       accumulators and scores
//   state_t           : controller states (IDLE, MAC, FINISH)
//   fxmul()           : fixed-point multiply, full-width product, arithmetic
//                       shift right by the fraction width, low word kept
package nn_pkg;

    localparam int DATA_W    = 128;
    localparam int FRAC_BITS = 64;

    typedef logic signed [DATA_W-1:0] data_t;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        FINISH
    } state_t;

    // The arithmetic shift floors the product, so results round toward -inf.
    function automatic data_t fxmul(input data_t a, input data_t b, input int unsigned frac);
        logic signed [2*DATA_W-1:0] wide_a;
        logic signed [2*DATA_W-1:0] wide_b;
        logic signed [2*DATA_W-1:0] prod;
        wide_a = a;
        wide_b = b;
        prod   = wide_a * wide_b;
        prod   = prod >>> frac;
        return prod[DATA_W-1:0];
    endfunction

endpackage

// File: rtl/nn_mac_lane.sv
// nn_mac_lane: one output neuron's accumulator.
//
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   load       : preload the accumulator with bias (start of a run)
//   en         : add fxmul(weight, x) to the accumulator this cycle
//   bias       : bias word for this neuron
//   weight     : weight for the input index currently being processed
//   x          : input word currently being processed
//   acc        : running accumulator (wraps on overflow)
module nn_mac_lane
    import nn_pkg::*;
#(
    parameter int FRAC_BITS = nn_pkg::FRAC_BITS
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  load,
    input  logic  en,
    input  data_t bias,
    input  data_t weight,
    input  data_t x,
    output data_t acc
);

    // Load takes priority over accumulate; the controller never asserts both.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (load) begin
            acc <= bias;
        end else if (en) begin
            acc <= acc + fxmul(weight, x, FRAC_BITS);
        end
    end

endmodule

// File: rtl/neural_net.sv
// neural_net: single fully-connected inference layer.
//
// OUT_N MAC lanes walk the IN_WIDTH inputs one index per clock, starting
// from the bias of each neuron, then publish the scores with a done pulse.
// A run takes IN_WIDTH+2 cycles from the start edge to the next start edge.
//
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   start      : request an inference (sampled only when idle)
//   ins        : image words, held stable for the whole run
//   outs       : registered scores, updated on the done cycle only
//   busy       : high while a run is in flight
//   done       : one-cycle pulse when outs is updated
//   class_idx  : (NN_ARGMAX_EN only) index of the highest signed score,
//                lowest index on a tie
//
// Configuration macros:
//   NN_ARGMAX_EN : adds class_idx and its comparator
//
// ROM contents come from the packed WEIGHT_INIT / BIAS_INIT parameters
// (entry k occupies bits [k*DATA_W +: DATA_W], weight k = j*IN_WIDTH+i).
// WEIGHT_FILE / BIAS_FILE name the matching image files for reference.
module neural_net
    import nn_pkg::*;
#(
    parameter int IN_WIDTH  = 784,
    parameter int OUT_N     = 10,
    parameter int DATA_W    = nn_pkg::DATA_W,
    parameter int FRAC_BITS = nn_pkg::FRAC_BITS,
    parameter string WEIGHT_FILE = "weights.mem",
    parameter string BIAS_FILE   = "biases.mem",
    parameter logic [OUT_N*IN_WIDTH*DATA_W-1:0] WEIGHT_INIT = '0,
    parameter logic [OUT_N*DATA_W-1:0]          BIAS_INIT   = '0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic signed [DATA_W-1:0] ins  [IN_WIDTH],
    output logic signed [DATA_W-1:0] outs [OUT_N],
    output logic                     busy,
    output logic                     done
`ifdef NN_ARGMAX_EN
    ,
    output logic [$clog2(OUT_N)-1:0] class_idx
`endif
);

    localparam int IDX_W = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(IN_WIDTH - 1);

    state_t           state_q;
    state_t           state_d;
    logic [IDX_W-1:0] idx;
    logic             load;
    logic             en;
    logic             capture;

    data_t weight_rom [OUT_N][IN_WIDTH];
    data_t bias_rom   [OUT_N];
    data_t acc        [OUT_N];

    for (genvar j = 0; j < OUT_N; j++) begin : g_rom_row
        assign bias_rom[j] = BIAS_INIT[j*DATA_W +: DATA_W];
        for (genvar i = 0; i < IN_WIDTH; i++) begin : g_rom_col
            assign weight_rom[j][i] = WEIGHT_INIT[(j*IN_WIDTH + i)*DATA_W +: DATA_W];
        end
    end

    // All lanes share the same input index; each reads its own weight row.
    for (genvar j = 0; j < OUT_N; j++) begin : g_lane
        nn_mac_lane #(
            .FRAC_BITS(FRAC_BITS)
        ) u_lane (
            .clk    (clk),
            .rst_n  (rst_n),
            .load   (load),
            .en     (en),
            .bias   (bias_rom[j]),
            .weight (weight_rom[j][idx]),
            .x      (ins[idx]),
            .acc    (acc[j])
        );
    end

    // Next-state and per-cycle lane controls.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        en      = 1'b0;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = MAC;
                end
            end
            MAC: begin
                en = 1'b1;
                if (idx == LAST_IDX) begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                capture = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // busy follows the state being entered, so it rises on the start edge
    // and falls on the same edge that raises done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            busy    <= (state_d != IDLE);
            done    <= capture;
            if (load) begin
                idx <= '0;
            end else if (en) begin
                idx <= idx + IDX_W'(1);
            end
        end
    end

`ifdef NN_ARGMAX_EN
    localparam int CLS_W = $clog2(OUT_N);

    data_t            best_val;
    logic [CLS_W-1:0] best_idx;

    // Strict greater-than keeps the lowest index on ties.
    always_comb begin
        best_val = acc[0];
        best_idx = '0;
        for (int j = 1; j < OUT_N; j++) begin
            if (acc[j] > best_val) begin
                best_val = acc[j];
                best_idx = CLS_W'(j);
            end
        end
    end
`endif

    // Scores are only published on the FINISH cycle and hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < OUT_N; j++) begin
                outs[j] <= '0;
            end
`ifdef NN_ARGMAX_EN
            class_idx <= '0;
`endif
        end else if (capture) begin
            for (int j = 0; j < OUT_N; j++) begin
                outs[j] <= acc[j];
            end
`ifdef NN_ARGMAX_EN
            class_idx <= best_idx;
`endif
        end
    end

endmodule

// File: tb/tb_neural_net.sv
// tb_neural_net: directed, table-driven bench for neural_net with a small
// 4-input, 2-output configuration.
//
// Neuron 0: weights {0.5, -1.0, 0, 0}, bias 0.25
// Neuron 1: weights {1.0, 1.0, 1.0, 1.0}, bias 0
// Build with +define+NN_ARGMAX_EN to also check class_idx.
module tb_neural_net;

    localparam int IN_N  = 4;
    localparam int OUT_K = 2;
    localparam int DW    = 128;

    localparam logic [DW-1:0] ZERO    = '0;
    localparam logic [DW-1:0] ONE     = 128'd1 << 64;
    localparam logic [DW-1:0] HALF    = 128'd1 << 63;
    localparam logic [DW-1:0] QUARTER = 128'd1 << 62;
    localparam logic [DW-1:0] MONE    = 128'd0 - (128'd1 << 64);
    localparam logic [DW-1:0] BIG     = 128'd1 << 126;
    localparam logic [DW-1:0] ALL1    = '1;

    localparam logic [OUT_K*IN_N*DW-1:0] TB_W = {ONE, ONE, ONE, ONE, ZERO, ZERO, MONE, HALF};
    localparam logic [OUT_K*DW-1:0]      TB_B = {ZERO, QUARTER};

    typedef struct packed {
        logic [DW-1:0] x0;
        logic [DW-1:0] x1;
        logic [DW-1:0] x2;
        logic [DW-1:0] x3;
        logic [DW-1:0] e0;
        logic [DW-1:0] e1;
        logic          cls;
    } vec_t;

    logic                 clk;
    logic                 rst_n;
    logic                 start;
    logic signed [DW-1:0] ins  [IN_N];
    logic signed [DW-1:0] outs [OUT_K];
    logic                 busy;
    logic                 done;
`ifdef NN_ARGMAX_EN
    logic [0:0]           class_idx;
`endif

    int total;
    int bad;

    vec_t vecs [6];

    neural_net #(
        .IN_WIDTH    (IN_N),
        .OUT_N       (OUT_K),
        .DATA_W      (DW),
        .FRAC_BITS   (64),
        .WEIGHT_INIT (TB_W),
        .BIAS_INIT   (TB_B)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .ins       (ins),
        .outs      (outs),
        .busy      (busy),
        .done      (done)
`ifdef NN_ARGMAX_EN
        ,
        .class_idx (class_idx)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Integer value in Q64.64.
    function automatic logic [DW-1:0] q(input int whole);
        logic signed [DW-1:0] t;
        t = whole;
        return t << 64;
    endfunction

    task automatic check_output(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_ins(input vec_t v);
        ins[0] = v.x0;
        ins[1] = v.x1;
        ins[2] = v.x2;
        ins[3] = v.x3;
    endtask

    // Pulse start for one edge, then count edges until done is seen.
    task automatic apply_stimulus(input vec_t v, output int edges);
        set_ins(v);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check_output("busy_after_start", busy, 1);
        edges = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (done) break;
        end
    endtask

    initial begin
        int edges;
        int cyc;
        int last;
        int pulses;
        total = 0;
        bad   = 0;

        vecs[0] = '{x0: q(1), x1: q(2), x2: q(3), x3: q(4),
                    e0: q(-1) - QUARTER, e1: q(10), cls: 1'b1};
        vecs[1] = '{x0: q(2), x1: q(1), x2: ZERO, x3: ZERO,
                    e0: QUARTER, e1: q(3), cls: 1'b1};
        vecs[2] = '{x0: ZERO, x1: ZERO, x2: QUARTER, x3: ZERO,
                    e0: QUARTER, e1: QUARTER, cls: 1'b0};
        vecs[3] = '{x0: ALL1, x1: ZERO, x2: ZERO, x3: ZERO,
                    e0: QUARTER - 128'd1, e1: ALL1, cls: 1'b0};
        vecs[4] = '{x0: q(-2), x1: q(-1), x2: ZERO, x3: ZERO,
                    e0: QUARTER, e1: q(-3), cls: 1'b0};
        vecs[5] = '{x0: ZERO, x1: ZERO, x2: BIG, x3: BIG,
                    e0: QUARTER, e1: 128'd1 << 127, cls: 1'b0};

        // Reset state.
        rst_n = 1'b0;
        start = 1'b0;
        for (int i = 0; i < IN_N; i++) ins[i] = '0;
        #2;
        check_output("reset_outs0", outs[0], ZERO);
        check_output("reset_outs1", outs[1], ZERO);
        check_output("reset_busy", busy, 0);
        check_output("reset_done", done, 0);
`ifdef NN_ARGMAX_EN
        check_output("reset_class", class_idx, 0);
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check_output("idle_busy", busy, 0);
            check_output("idle_done", done, 0);
        end
        check_output("idle_outs0", outs[0], ZERO);

        // Table of single runs.
        for (int i = 0; i < 6; i++) begin
            apply_stimulus(vecs[i], edges);
            $display("[TB] vector %0d done after %0d edges", i, edges);
            check_output("latency", edges, IN_N + 1);
            check_output("vec_outs0", outs[0], vecs[i].e0);
            check_output("vec_outs1", outs[1], vecs[i].e1);
            check_output("vec_busy_at_done", busy, 0);
`ifdef NN_ARGMAX_EN
            check_output("vec_class", class_idx, vecs[i].cls);
`endif
            @(negedge clk);
            check_output("done_one_cycle", done, 0);
            check_output("vec_outs0_hold", outs[0], vecs[i].e0);
            repeat (2) @(negedge clk);
        end

        // Start while busy is ignored.
        set_ins(vecs[1]);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        pulses = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check_output("busy_start_pulses", pulses, 1);
        check_output("busy_start_outs0", outs[0], vecs[1].e0);
        check_output("busy_start_outs1", outs[1], vecs[1].e1);

        // Reset in the middle of a run.
        set_ins(vecs[0]);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_output("midrst_outs0", outs[0], ZERO);
        check_output("midrst_outs1", outs[1], ZERO);
        check_output("midrst_busy", busy, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check_output("midrst_no_done", pulses, 0);
        check_output("midrst_outs_stay", outs[1], ZERO);
        apply_stimulus(vecs[0], edges);
        check_output("after_rst_latency", edges, IN_N + 1);
        check_output("after_rst_outs0", outs[0], vecs[0].e0);
        check_output("after_rst_outs1", outs[1], vecs[0].e1);
        repeat (2) @(negedge clk);

        // Back-to-back runs with start held high.
        set_ins(vecs[1]);
        start  = 1'b1;
        cyc    = 0;
        last   = 0;
        pulses = 0;
        for (int k = 0; k < 40 && pulses < 3; k++) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (done) begin
                if (pulses > 0) check_output("b2b_period", cyc - last, IN_N + 2);
                check_output("b2b_outs0", outs[0], vecs[1].e0);
                check_output("b2b_outs1", outs[1], vecs[1].e1);
                last = cyc;
                pulses++;
            end
        end
        check_output("b2b_pulses", pulses, 3);
        start = 1'b0;
        repeat (10) @(negedge clk);
        check_output("b2b_idle_busy", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
